// File: rtl/axis_byte_packer_if.sv
// AXI-Stream beat bundle used on both sides of axis_byte_packer.
interface axis_byte_packer_if #(
    parameter int DATA_WD = 32
) ();
    localparam int DATA_BYTE_WD = DATA_WD / 8;

    logic                    valid;
    logic [DATA_WD-1:0]      data;
    logic [DATA_BYTE_WD-1:0] keep;
    logic                    last;
    logic                    ready;

    modport master (output valid, output data, output keep, output last, input ready);
    modport slave  (input valid, input data, input keep, input last, output ready);
endinterface

// File: rtl/axis_byte_packer.sv
// Registered AXI-Stream byte packer: MSB-aligned partial beats in, dense beats out.
// Optional keep-format checker enabled by defining AXIS_PACKER_KEEP_CHECK_EN.
module axis_byte_packer #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                clk,
    input  logic                rst,
    axis_byte_packer_if.slave   up,
    axis_byte_packer_if.master  down,
    output logic                err_keep
);
    typedef logic [BYTE_CNT_WD:0] cnt_t;
    typedef enum logic {ACCEPT, TAIL} state_t;

    localparam cnt_t FULL = cnt_t'(DATA_BYTE_WD);

    state_t                  state, state_nx;
    logic [DATA_WD-1:0]      res_data, res_data_nx;
    cnt_t                    res_cnt, res_cnt_nx;
    logic                    valid_q, valid_nx;
    logic [DATA_WD-1:0]      data_q, data_nx;
    logic [DATA_BYTE_WD-1:0] keep_q, keep_nx;
    logic                    last_q, last_nx;

    logic                    slot_free;
    logic                    accept;
    cnt_t                    in_cnt;
    cnt_t                    cnt;
    logic [DATA_WD-1:0]      in_masked;
    logic [BYTE_CNT_WD+3:0]  shift;
    logic [2*DATA_WD-1:0]    comb;

    function automatic logic [DATA_BYTE_WD-1:0] keep_of(input cnt_t n);
        keep_of = '0;
        for (int unsigned i = 0; i < DATA_BYTE_WD; i++)
            if (cnt_t'(i) < n) keep_of[DATA_BYTE_WD-1-i] = 1'b1;
    endfunction

    assign slot_free  = !valid_q || down.ready;
    assign up.ready   = (state == ACCEPT) && slot_free && !rst;
    assign accept     = up.valid && up.ready;
    assign down.valid = valid_q;
    assign down.data  = data_q;
    assign down.keep  = keep_q;
    assign down.last  = last_q;

    // Only the leading in_cnt bytes are taken, so junk in unused lanes never leaks out.
    always_comb begin
        in_cnt    = '0;
        in_masked = '0;
        for (int unsigned i = 0; i < DATA_BYTE_WD; i++)
            in_cnt = in_cnt + cnt_t'(up.keep[i]);
        for (int unsigned i = 0; i < DATA_BYTE_WD; i++)
            if (cnt_t'(i) < in_cnt)
                in_masked[DATA_WD-1-8*i -: 8] = up.data[DATA_WD-1-8*i -: 8];
    end

    assign cnt   = res_cnt + in_cnt;
    assign shift = {res_cnt, 3'b000};
    assign comb  = {res_data, {DATA_WD{1'b0}}} | ({in_masked, {DATA_WD{1'b0}}} >> shift);

    always_comb begin
        state_nx    = state;
        res_data_nx = res_data;
        res_cnt_nx  = res_cnt;
        valid_nx    = valid_q;
        data_nx     = data_q;
        keep_nx     = keep_q;
        last_nx     = last_q;
        if (slot_free) valid_nx = 1'b0;

        case (state)
            ACCEPT: begin
                if (accept) begin
                    if (!up.last) begin
                        if (cnt >= FULL) begin
                            valid_nx    = 1'b1;
                            data_nx     = comb[2*DATA_WD-1:DATA_WD];
                            keep_nx     = '1;
                            last_nx     = 1'b0;
                            res_data_nx = comb[DATA_WD-1:0];
                            res_cnt_nx  = cnt - FULL;
                        end else begin
                            res_data_nx = comb[2*DATA_WD-1:DATA_WD];
                            res_cnt_nx  = cnt;
                        end
                    end else if (cnt == '0) begin
                        res_data_nx = '0;
                        res_cnt_nx  = '0;
                    end else if (cnt <= FULL) begin
                        valid_nx    = 1'b1;
                        data_nx     = comb[2*DATA_WD-1:DATA_WD];
                        keep_nx     = keep_of(cnt);
                        last_nx     = 1'b1;
                        res_data_nx = '0;
                        res_cnt_nx  = '0;
                    end else begin
                        valid_nx    = 1'b1;
                        data_nx     = comb[2*DATA_WD-1:DATA_WD];
                        keep_nx     = '1;
                        last_nx     = 1'b0;
                        res_data_nx = comb[DATA_WD-1:0];
                        res_cnt_nx  = cnt - FULL;
                        state_nx    = TAIL;
                    end
                end
            end
            TAIL: begin
                if (slot_free) begin
                    valid_nx    = 1'b1;
                    data_nx     = res_data;
                    keep_nx     = keep_of(res_cnt);
                    last_nx     = 1'b1;
                    res_data_nx = '0;
                    res_cnt_nx  = '0;
                    state_nx    = ACCEPT;
                end
            end
            default: state_nx = ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACCEPT;
            res_data <= '0;
            res_cnt  <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            keep_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            res_data <= res_data_nx;
            res_cnt  <= res_cnt_nx;
            valid_q  <= valid_nx;
            data_q   <= data_nx;
            keep_q   <= keep_nx;
            last_q   <= last_nx;
        end
    end

`ifdef AXIS_PACKER_KEEP_CHECK_EN
    logic keep_bad;
    // A well-formed keep equals the MSB-first mask of its own popcount.
    assign keep_bad = (up.keep != keep_of(in_cnt)) || ((in_cnt == '0) && !up.last);

    always_ff @(posedge clk) begin
        if (rst)                      err_keep <= 1'b0;
        else if (accept && keep_bad)  err_keep <= 1'b1;
    end
`else
    assign err_keep = 1'b0;
`endif
endmodule

// File: tb/tb_axis_byte_packer.sv
// Scoreboard bench for axis_byte_packer (DATA_WD=32) with directed vectors.
module tb_axis_byte_packer;
    localparam int DW = 32;
`ifdef AXIS_PACKER_KEEP_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic err_keep;
    always #5 clk = ~clk;

    axis_byte_packer_if #(.DATA_WD(DW)) up ();
    axis_byte_packer_if #(.DATA_WD(DW)) down ();

    axis_byte_packer #(.DATA_WD(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .up       (up),
        .down     (down),
        .err_keep (err_keep)
    );

    beat_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    bit    toggle_mode = 1'b0;
    bit    mirror_chk  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        exp_q.push_back(b);
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n = 0;
        up.valid = 1'b1;
        up.data  = d;
        up.keep  = k;
        up.last  = l;
        @(negedge clk);
        while (!up.ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!up.ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: ready_in stuck at 0 for data %h", d);
        end
        @(posedge clk);
        #1;
        up.valid = 1'b0;
        up.data  = 32'h5A5A5A5A;
        up.keep  = 4'b0000;
        up.last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || down.valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || down.valid) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d beats outstanding, valid_out %b", exp_q.size(), down.valid);
        end
        @(posedge clk);
        #1;
    endtask

    // Downstream ready: constant 1 or toggling each cycle.
    initial begin
        down.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            down.ready = toggle_mode ? ~down.ready : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each output handshake, checks hold while stalled.
    initial begin
        logic  prev_stall = 1'b0;
        beat_t prev_beat;
        beat_t got;
        beat_t want;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                got.data = down.data;
                got.keep = down.keep;
                got.last = down.last;
                if (prev_stall)
                    check("hold_stable", {27'd0, down.valid, got}, {27'd0, 1'b1, prev_beat});
                if (mirror_chk)
                    check("ready_mirror", {63'd0, up.ready}, {63'd0, (!down.valid || down.ready)});
                if (down.valid && down.ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_beat: got %h nothing expected", got);
                    end else begin
                        want = exp_q.pop_front();
                        check("out_beat", {27'd0, got}, {27'd0, want});
                    end
                end
                prev_stall = down.valid && !down.ready;
                prev_beat  = got;
            end
        end
    end

    initial begin
        up.valid = 1'b0;
        up.data  = '0;
        up.keep  = '0;
        up.last  = 1'b0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {63'd0, down.valid}, 64'd0);
        check("rst_data",  {32'd0, down.data}, 64'd0);
        check("rst_keep",  {60'd0, down.keep}, 64'd0);
        check("rst_last",  {63'd0, down.last}, 64'd0);
        check("rst_err",   {63'd0, err_keep}, 64'd0);
        check("rst_ready", {63'd0, up.ready}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Partial beats packed across three inputs.
        expect_beat(32'hAABBCCDD, 4'b1111, 1'b0);
        expect_beat(32'hEEFF0000, 4'b1100, 1'b1);
        send(32'hAABBCC11, 4'b1110, 1'b0);
        send(32'hDDEE2233, 4'b1100, 1'b0);
        send(32'hFF445566, 4'b1000, 1'b1);

        // Tail overflow: residual of 3 plus a full last beat.
        expect_beat(32'hA1A2A3B1, 4'b1111, 1'b0);
        expect_beat(32'hB2B3B400, 4'b1110, 1'b1);
        send(32'hA1A2A377, 4'b1110, 1'b0);
        send(32'hB1B2B3B4, 4'b1111, 1'b1);
        check("tail_ready", {63'd0, up.ready}, 64'd0);
        drain();

        // Full beats under toggling backpressure.
        toggle_mode = 1'b1;
        mirror_chk  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] d;
            d = 32'h01020304 + 32'h10101010 * i;
            expect_beat(d, 4'b1111, (i == 5));
            send(d, 4'b1111, (i == 5));
        end
        drain();
        mirror_chk  = 1'b0;
        toggle_mode = 1'b0;
        @(posedge clk);
        #1;

        // Empty packet dropped, next packet unaffected.
        expect_beat(32'h11223344, 4'b1111, 1'b1);
        send(32'h12345678, 4'b0000, 1'b1);
        send(32'h11223344, 4'b1111, 1'b1);
        drain();

        // Reset with two residual bytes pending.
        send(32'hAABB9999, 4'b1100, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", {63'd0, up.ready}, 64'd0);
        @(posedge clk);
        #1;
        check("midrst_out", {27'd0, down.valid, down.data, down.keep, down.last}, 64'd0);
        rst = 1'b0;
        expect_beat(32'h55667788, 4'b1111, 1'b1);
        send(32'h55667788, 4'b1111, 1'b1);
        drain();

        // Keep-format error flag.
        check("err_clean", {63'd0, err_keep}, 64'd0);
        send(32'h12345678, 4'b1010, 1'b0);
        @(negedge clk);
        check("err_set", {63'd0, err_keep}, {63'd0, EXP_ERR});
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("err_sticky", {63'd0, err_keep}, {63'd0, EXP_ERR});
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("err_cleared", {63'd0, err_keep}, 64'd0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/axis_byte_packer.md
# axis_byte_packer

Sequential AXI-Stream byte packer for the header-insertion datapath. Accepts beats whose valid bytes are MSB-aligned but partially filled, and emits densely packed full-width beats. A residual register carries leftover bytes between beats. On `last_in` it flushes the residual, using one extra tail beat if the final bytes overflow a single beat. It is the registered, flow-controlled, width-generic successor of the combinational two-beat combiner and sits between the header/payload merge point and the stream output.

## Interface
- `DATA_WD`, 32: data width in bits; must be a multiple of 8, minimum 16.
- `DATA_BYTE_WD`, `DATA_WD/8`: bytes per beat.
- `BYTE_CNT_WD`, `$clog2(DATA_BYTE_WD)`: byte-count width; all counts are `BYTE_CNT_WD+1` bits.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `valid_in`  in  1  input beat valid.
- `data_in`  in  `DATA_WD`  input data; stream byte 0 at `[DATA_WD-1 -: 8]`.
- `keep_in`  in  `DATA_BYTE_WD`  byte enables; MSB-aligned contiguous ones (e.g. `4'b1100`).
- `last_in`  in  1  final beat of packet.
- `ready_in`  out  1  packer accepts input this cycle.
- `valid_out`  out  1  output beat valid.
- `data_out`  out  `DATA_WD`  packed data; unused bytes are zero.
- `keep_out`  out  `DATA_BYTE_WD`  MSB-aligned keep.
- `last_out`  out  1  final beat of packet.
- `ready_out`  in  1  downstream accepts output.
- `err_keep`  out  1  sticky keep-format error (see Configuration).

## Operation
- State: `res_data` (`DATA_WD`, MSB-aligned), `res_cnt` (0..`DATA_BYTE_WD-1`), output register, and FSM {`ACCEPT`, `TAIL`}.
- `slot_free = !valid_out || ready_out`.
- `ready_in = (state==ACCEPT) && slot_free && !rst`.
- Accept: `valid_in && ready_in`. Define `in_cnt = popcount(keep_in)` and `cnt = res_cnt + in_cnt`. Incoming bytes are appended directly after the residual bytes.
- Accept, `!last_in`, `cnt >= DATA_BYTE_WD`:
  - Emit the first `DATA_BYTE_WD` bytes with keep all-ones and `last_out=0`.
  - Residual becomes the remaining `cnt-DATA_BYTE_WD` bytes, MSB-aligned.
- Accept, `!last_in`, `cnt < DATA_BYTE_WD`: append to residual and emit nothing.
- Accept, `last_in`, `cnt==0`: emit nothing. The empty packet is dropped.
- Accept, `last_in`, `0<cnt<=DATA_BYTE_WD`: emit `cnt` bytes with `keep_out` = `cnt` ones from the MSB and `last_out=1`; set `res_cnt=0`.
- Accept, `last_in`, `cnt>DATA_BYTE_WD`: emit a full beat with `last_out=0`, keep the excess in the residual, and go to `TAIL`.
- `TAIL`: when `slot_free`, emit the residual bytes with `last_out=1` and set `res_cnt=0`. Then go to `ACCEPT`. No input is accepted while in `TAIL`.
- Cycles with `slot_free` and no new beat produced set `valid_out=0`.
- While `valid_out && !ready_out`, the output registers are held stable.
- Packet boundaries are never merged: residual bytes always leave with the packet's last beat.

## Timing
- Reset values: `valid_out=0`, `data_out=0`, `keep_out=0`, `last_out=0`, `err_keep=0`, `res_cnt=0`, state `ACCEPT`. `ready_in=0` while `rst` is high.
- Latency: a beat-producing accept at edge N drives `valid_out=1` after edge N.
- Throughput: one input beat per cycle while downstream is ready. A packet with tail overflow costs exactly one input stall cycle.
- `ready_in` depends combinationally on `ready_out`, `valid_out` and state. No combinational path from `valid_in` to `ready_in`.
- Output beat count per packet is `ceil(total_bytes/DATA_BYTE_WD)`.
- Reset mid-packet discards the residual, output beat and `TAIL` state on the next edge.

## Configuration
- `AXIS_PACKER_KEEP_CHECK_EN` defined:
  - On every accepted beat, sets `err_keep` (sticky until `rst`) if `keep_in` is not of the form ones-then-zeros from the MSB.
  - Also sets it if `keep_in==0` with `last_in=0`.
  - Datapath behaviour is unchanged; bytes are counted by popcount.
- Not defined: `err_keep` tied to 0 and no check logic is generated.

## Test plan
- `DATA_WD=32`, beats `AABBCC__`/`1110`, `DDEE____`/`1100`, `FF______`/`1000`+last -> outputs `AABBCCDD`/`1111`/last0, then `EEFF0000`/`1100`/last1.
- Residual `A1A2A3` plus last beat `B1B2B3B4`/`1111` -> `A1A2A3B1`/`1111`/last0, then `B2B3B4 00`/`1110`/last1; `ready_in=0` during the `TAIL` cycle.
- Continuous full beats `1111` with `ready_out` toggling 1,0,1,0 -> no data loss or duplication, outputs stable while stalled, `ready_in` mirrors `slot_free`.
- Single beat `keep=0000`+last -> no output; next packet `11223344`/`1111`+last -> passes unchanged with last1.
- `rst` asserted one cycle after `res_cnt=2` -> all outputs 0, next packet has no stale bytes.
- With `AXIS_PACKER_KEEP_CHECK_EN`: accept `keep=1010` -> `err_keep=1` after that edge, held until `rst`. Without the macro: `err_keep` stays 0.
